// File: rtl/tb_tohost_monitor_if.sv
// Snooped data-memory write channel between the core and its data memory.
// The monitor only listens, so its modport has no outputs.
interface tb_tohost_monitor_if #(
    parameter int ADDR_W = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    modport master (
        output wr_valid,
        output wr_ready,
        output wr_addr,
        output wr_data,
        output wr_strb
    );

    modport slave (
        input wr_valid,
        input wr_ready,
        input wr_addr,
        input wr_data,
        input wr_strb
    );
endinterface

// File: rtl/tb_tohost_monitor.sv
// Completion monitor for core benches: watches tohost/console writes and
// produces sticky pass/fail/timeout verdicts plus a RUN cycle count.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_RUN     | test executing; counting cycles, forwarding console bytes
//   S_PASS    | tohost written with 1; terminal until reset
//   S_FAIL    | tohost odd value != 1, or partial-strobe write; terminal
//   S_TIMEOUT | TIMEOUT cycles elapsed without verdict; terminal
module tb_tohost_monitor #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(32'h0000_1004),
    parameter int                TIMEOUT      = 100000,
    parameter int                CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tb_tohost_monitor_if.slave      bus,
    output logic                    done,
    output logic                    pass,
    output logic                    timed_out,
    output logic [30:0]             fail_code,
    output logic [CNT_W-1:0]        cycles,
    output logic                    putc_valid,
    output logic [7:0]              putc_char
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] CYC_TC    = CNT_W'(TIMEOUT - 1);
    localparam logic [30:0]      PROTO_ERR = 31'h7FFF_FFFF;

    state_t state;
    logic   xfer;
    logic   hit_tohost;
    logic   hit_console;

    assign xfer        = bus.wr_valid & bus.wr_ready;
    assign hit_tohost  = xfer && (bus.wr_addr == TOHOST_ADDR);
    assign hit_console = xfer && (bus.wr_addr == CONSOLE_ADDR) && bus.wr_strb[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            done       <= 1'b0;
            pass       <= 1'b0;
            timed_out  <= 1'b0;
            fail_code  <= '0;
            cycles     <= '0;
            putc_valid <= 1'b0;
            putc_char  <= '0;
        end else begin
            putc_valid <= 1'b0;
            if (state == S_RUN) begin
                if (!(&cycles)) begin
                    cycles <= cycles + CNT_W'(1);
                end
                if (hit_console) begin
                    putc_valid <= 1'b1;
                    putc_char  <= bus.wr_data[7:0];
                end
                // tohost verdict takes priority over the timeout threshold
                if (hit_tohost && (bus.wr_strb != 4'hF)) begin
                    state     <= S_FAIL;
                    done      <= 1'b1;
                    fail_code <= PROTO_ERR;
                end else if (hit_tohost && (bus.wr_data == 32'd1)) begin
                    state <= S_PASS;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else if (hit_tohost && bus.wr_data[0]) begin
                    state     <= S_FAIL;
                    done      <= 1'b1;
                    fail_code <= bus.wr_data[31:1];
                end else if (cycles == CYC_TC) begin
                    state     <= S_TIMEOUT;
                    done      <= 1'b1;
                    timed_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tb_tohost_monitor.sv
// Randomized + directed bench for tb_tohost_monitor against a verdict-level model.
`timescale 1ns/1ps
module tb_tb_tohost_monitor;

    localparam int          TO      = 20;
    localparam logic [31:0] A_HOST  = 32'h0000_1000;
    localparam logic [31:0] A_CONS  = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done, pass, timed_out, putc_valid;
    logic [30:0] fail_code;
    logic [31:0] cycles;
    logic [7:0]  putc_char;

    int checks = 0;
    int errors = 0;

    tb_tohost_monitor_if #(.ADDR_W(32)) bus ();

    tb_tohost_monitor #(
        .ADDR_W(32), .TOHOST_ADDR(A_HOST), .CONSOLE_ADDR(A_CONS),
        .TIMEOUT(TO), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .done(done), .pass(pass), .timed_out(timed_out),
        .fail_code(fail_code), .cycles(cycles),
        .putc_valid(putc_valid), .putc_char(putc_char)
    );

    always #5 clk = ~clk;

    // Reference: verdict is 0 running, 1 pass, 2 fail, 3 timeout.
    int          m_verdict;
    longint      m_edges;
    logic [30:0] m_code;
    logic        m_pv;
    logic [7:0]  m_pc;
    logic        m_xfer;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_verdict = 0; m_edges = 0; m_code = '0; m_pv = 1'b0; m_pc = '0;
        end else begin
            m_xfer = bus.wr_valid && bus.wr_ready;
            m_pv   = 1'b0;
            if (m_verdict == 0) begin
                m_edges = m_edges + 1;
                if (m_xfer && bus.wr_addr == A_CONS && bus.wr_strb[0]) begin
                    m_pv = 1'b1;
                    m_pc = bus.wr_data[7:0];
                end
                if (m_xfer && bus.wr_addr == A_HOST && bus.wr_strb != 4'hF) begin
                    m_verdict = 2; m_code = 31'h7FFF_FFFF;
                end else if (m_xfer && bus.wr_addr == A_HOST && bus.wr_data % 2 == 1) begin
                    if (bus.wr_data == 1) m_verdict = 1;
                    else begin m_verdict = 2; m_code = 31'(bus.wr_data / 2); end
                end else if (m_edges == TO) begin
                    m_verdict = 3;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("done",       64'(done),       64'(m_verdict != 0));
        chk("pass",       64'(pass),       64'(m_verdict == 1));
        chk("timed_out",  64'(timed_out),  64'(m_verdict == 3));
        chk("fail_code",  64'(fail_code),  64'(m_code));
        chk("cycles",     64'(cycles),     64'(m_edges));
        chk("putc_valid", 64'(putc_valid), 64'(m_pv));
        chk("putc_char",  64'(putc_char),  64'(m_pc));
    endtask

    // Drive one cycle of inputs (called at a falling edge), then compare after the next falling edge.
    task automatic cyc(input logic v, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        bus.wr_valid = v; bus.wr_ready = r; bus.wr_addr = a;
        bus.wr_data = d;  bus.wr_strb = s;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, A_HOST, 32'd1, 4'hF);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_ready = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.wr_strb = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ra, rd;
        do_reset();
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_putc", 64'(putc_valid), 64'd0);
        compare_all();

        // Pass at cycle 10
        idle(9);
        cyc(1'b1, 1'b1, A_HOST, 32'd1, 4'hF);
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_cycles", 64'(cycles), 64'd10);
        idle(5);
        chk("t1_cycles_held", 64'(cycles), 64'd10);

        // Fail with code 3, later pass write ignored
        do_reset();
        cyc(1'b1, 1'b1, A_HOST, 32'h7, 4'hF);
        chk("t2_code", 64'(fail_code), 64'd3);
        chk("t2_pass", 64'(pass), 64'd0);
        cyc(1'b1, 1'b1, A_HOST, 32'd1, 4'hF);
        chk("t2_code_held", 64'(fail_code), 64'd3);
        chk("t2_pass_held", 64'(pass), 64'd0);

        // Timeout boundary
        do_reset();
        idle(TO - 1);
        chk("t3_not_yet", 64'(done), 64'd0);
        idle(1);
        chk("t3_timeout", 64'(timed_out), 64'd1);
        chk("t3_cycles", 64'(cycles), 64'(TO));
        do_reset();
        idle(TO - 1);
        cyc(1'b1, 1'b1, A_HOST, 32'd1, 4'hF);
        chk("t3_pass_wins", 64'(pass), 64'd1);
        chk("t3_no_timeout", 64'(timed_out), 64'd0);

        // Console strobes
        do_reset();
        cyc(1'b1, 1'b1, A_CONS, 32'h4F, 4'h1);
        chk("t4_o_valid", 64'(putc_valid), 64'd1);
        chk("t4_o_char", 64'(putc_char), 64'h4F);
        cyc(1'b1, 1'b1, A_CONS, 32'h4B, 4'h1);
        chk("t4_k_valid", 64'(putc_valid), 64'd1);
        chk("t4_k_char", 64'(putc_char), 64'h4B);
        cyc(1'b1, 1'b0, A_CONS, 32'h21, 4'h1);
        chk("t4_stall", 64'(putc_valid), 64'd0);

        // Even value ignored, partial strobe is a protocol error
        do_reset();
        cyc(1'b1, 1'b1, A_HOST, 32'd2, 4'hF);
        chk("t5_even", 64'(done), 64'd0);
        cyc(1'b1, 1'b1, A_HOST, 32'd1, 4'h1);
        chk("t5_proto", 64'(fail_code), 64'h7FFF_FFFF);

        // Asynchronous reset between edges
        do_reset();
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cycles0", 64'(cycles), 64'd0);
        chk("t6_done0", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("t6_restart", 64'(cycles), 64'd1);

        // Randomized traffic, several runs
        for (int run = 0; run < 12; run++) begin
            do_reset();
            for (int i = 0; i < 30; i++) begin
                case ($urandom_range(0, 3))
                    0: ra = A_HOST;
                    1: ra = A_CONS;
                    2: ra = 32'h0000_1008;
                    default: ra = $urandom;
                endcase
                rd = $urandom;
                if (ra == A_HOST && $urandom_range(0, 3) != 0) rd[0] = 1'b0;
                if (ra == A_HOST && $urandom_range(0, 5) == 0) rd = 32'd1;
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), ra, rd,
                    ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
